// File: rtl/sd_write_photo_pkg.sv
// Shared BMP/SD definitions for the photo save and load paths.
// Holds the file-format constants, the sector FSM states and the RGB565 to RGB888 expansion.
package sd_write_photo_pkg;

  localparam int unsigned BMP_HEAD_NUM = 54;
  localparam int unsigned SD_SEC_WORDS = 256;
  localparam int unsigned HDR_WORDS    = BMP_HEAD_NUM / 2;

  localparam logic [7:0] BMP_MAGIC_B = 8'h42;
  localparam logic [7:0] BMP_MAGIC_M = 8'h4D;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREFETCH,
    S_START,
    S_WAIT,
    S_DONE
  } state_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb888_t;

  // Replicating the top bits into the low bits maps full-scale 565 values to 0xFF.
  function automatic rgb888_t rgb565_to_888(input logic [15:0] p);
    rgb888_t c;
    c.r = {p[15:11], p[15:13]};
    c.g = {p[10:5], p[10:9]};
    c.b = {p[4:0], p[4:2]};
    return c;
  endfunction

endpackage

// File: rtl/sd_write_photo_if.sv
// SDRAM read-port and SD sector-writer signals seen by the screenshot path.
// master = the screenshot block, slave = the SDRAM FIFO / SD writer side.
interface sd_write_photo_if;
  logic        sdram_rd_rst;
  logic        sdram_rd_en;
  logic [15:0] sdram_rd_data;
  logic        wr_start_en;
  logic [31:0] wr_sec_addr;
  logic        wr_busy;
  logic        wr_req;
  logic [15:0] wr_data;

  modport master (
    output sdram_rd_rst, sdram_rd_en, wr_start_en, wr_sec_addr, wr_data,
    input  sdram_rd_data, wr_busy, wr_req
  );

  modport slave (
    input  sdram_rd_rst, sdram_rd_en, wr_start_en, wr_sec_addr, wr_data,
    output sdram_rd_data, wr_busy, wr_req
  );
endinterface

// File: rtl/sd_write_photo_bmp_header_rom.sv
// Combinational 54-byte BMP header, returned as 27 big-endian-packed 16-bit words.
// Multi-byte header fields are little-endian inside the byte stream.
module bmp_header_rom
  import sd_write_photo_pkg::*;
#(
  parameter int unsigned IMG_W      = 640,
  parameter int unsigned IMG_H      = 480,
  parameter int unsigned FILE_BYTES = 921654
) (
  input  logic [4:0]  idx,
  output logic [15:0] word
);

  localparam logic [31:0] FB  = 32'(FILE_BYTES);
  localparam logic [31:0] W   = 32'(IMG_W);
  localparam logic [31:0] H   = 32'(IMG_H);
  localparam logic [31:0] IMG = 32'(3 * IMG_W * IMG_H);
  localparam logic [31:0] OFF = 32'(BMP_HEAD_NUM);
  localparam logic [31:0] DIB = 32'd40;

  function automatic logic [7:0] le_byte(input logic [31:0] v, input logic [1:0] n);
    return v[{n, 3'b000} +: 8];
  endfunction

  // Every 4-byte field starts on a byte index that is 2 mod 4, so one offset rule serves all.
  function automatic logic [7:0] hdr_byte(input logic [5:0] b);
    logic [7:0] r;
    logic [1:0] off;
    r   = 8'h00;
    off = b[1:0] - 2'd2;
    case (b) inside
      6'd0:          r = BMP_MAGIC_B;
      6'd1:          r = BMP_MAGIC_M;
      [6'd2:6'd5]:   r = le_byte(FB, off);
      [6'd10:6'd13]: r = le_byte(OFF, off);
      [6'd14:6'd17]: r = le_byte(DIB, off);
      [6'd18:6'd21]: r = le_byte(W, off);
      [6'd22:6'd25]: r = le_byte(H, off);
      6'd26:         r = 8'd1;
      6'd28:         r = 8'd24;
      [6'd34:6'd37]: r = le_byte(IMG, off);
      default:       r = 8'h00;
    endcase
    return r;
  endfunction

  always_comb begin
    word = {hdr_byte({idx, 1'b0}), hdr_byte({idx, 1'b1})};
  end

endmodule

// File: rtl/sd_write_photo.sv
// Screenshot path: streams one RGB565 frame from SDRAM out as a 24-bpp BMP file
// into consecutive SD sectors starting at SECTION_ADDR, zero-padding the last sector.
module sd_write_photo
  import sd_write_photo_pkg::*;
#(
  parameter logic [31:0] SECTION_ADDR = 32'd69760,
  parameter int unsigned IMG_W        = 640,
  parameter int unsigned IMG_H        = 480
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             capture_start,
  output logic             capture_busy,
  output logic             capture_done,
  sd_write_photo_if.master bus
);

  localparam int unsigned PIX_NUM     = IMG_W * IMG_H;
  localparam int unsigned FILE_BYTES  = BMP_HEAD_NUM + 3 * PIX_NUM;
  localparam int unsigned SEC_NUM     = (FILE_BYTES + 511) / 512;
  localparam int unsigned PIX_WORDS   = 3 * PIX_NUM / 2;
  localparam int unsigned TOTAL_WORDS = SEC_NUM * SD_SEC_WORDS;
  localparam int          WC_W        = $clog2(TOTAL_WORDS) + 1;

  state_t state, state_nxt;

  logic            busy_d0, busy_d1, busy_fall;
  logic            start_acc, req_ok, burst_go, refill_go, is_pix;
  logic            rd_more, pf_issued, cap_vld, cap_slot;
  logic [31:0]     rd_total;
  logic [15:0]     pix0, pix1;
  rgb888_t         c0, c1;
  logic [WC_W-1:0] word_cnt;
  logic [1:0]      ph;
  logic [15:0]     sec_cnt;
  logic [15:0]     hdr_word, word_nxt;

  bmp_header_rom #(
    .IMG_W      (IMG_W),
    .IMG_H      (IMG_H),
    .FILE_BYTES (FILE_BYTES)
  ) u_hdr (
    .idx  (word_cnt[4:0]),
    .word (hdr_word)
  );

  assign busy_fall    = busy_d1 & ~busy_d0;
  assign start_acc    = (state == S_IDLE) && capture_start;
  assign req_ok       = (state == S_WAIT) && bus.wr_req;
  assign refill_go    = req_ok && is_pix && (ph == 2'd2) && (rd_total != PIX_NUM);
  assign capture_busy = (state != S_IDLE);
  assign capture_done = (state == S_DONE);
  assign c0           = rgb565_to_888(pix0);
  assign c1           = rgb565_to_888(pix1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_d0 <= 1'b0;
      busy_d1 <= 1'b0;
    end else begin
      busy_d0 <= bus.wr_busy;
      busy_d1 <= busy_d0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    burst_go  = 1'b0;
    case (state)
      S_IDLE: begin
        if (capture_start) state_nxt = S_PREFETCH;
      end
      S_PREFETCH: begin
        burst_go = !pf_issued;
        if (cap_vld && cap_slot) state_nxt = S_START;
      end
      S_START: state_nxt = S_WAIT;
      S_WAIT: begin
        burst_go = refill_go;
        if (busy_fall) state_nxt = (sec_cnt == 16'(SEC_NUM - 1)) ? S_DONE : S_START;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // A burst is always two back-to-back reads; data lands one cycle later into pix0 then pix1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.sdram_rd_rst <= 1'b0;
      bus.sdram_rd_en  <= 1'b0;
      rd_more          <= 1'b0;
      rd_total         <= '0;
      pf_issued        <= 1'b0;
      cap_vld          <= 1'b0;
      cap_slot         <= 1'b0;
      pix0             <= '0;
      pix1             <= '0;
    end else begin
      bus.sdram_rd_rst <= start_acc;
      cap_vld          <= bus.sdram_rd_en;
      if (start_acc) begin
        bus.sdram_rd_en <= 1'b0;
        rd_more         <= 1'b0;
        rd_total        <= '0;
        pf_issued       <= 1'b0;
      end else if (burst_go) begin
        bus.sdram_rd_en <= 1'b1;
        rd_more         <= 1'b1;
        rd_total        <= rd_total + 32'd2;
        pf_issued       <= 1'b1;
      end else if (rd_more) begin
        bus.sdram_rd_en <= 1'b1;
        rd_more         <= 1'b0;
      end else begin
        bus.sdram_rd_en <= 1'b0;
      end
      if (start_acc) begin
        cap_slot <= 1'b0;
      end else if (cap_vld) begin
        if (cap_slot) pix1 <= bus.sdram_rd_data;
        else          pix0 <= bus.sdram_rd_data;
        cap_slot <= ~cap_slot;
      end
    end
  end

  // Three 16-bit words carry one pixel pair as B0 G0 | R0 B1 | G1 R1.
  always_comb begin
    word_nxt = 16'h0000;
    is_pix   = 1'b0;
    if (word_cnt < WC_W'(HDR_WORDS)) begin
      word_nxt = hdr_word;
    end else if (word_cnt < WC_W'(HDR_WORDS + PIX_WORDS)) begin
      is_pix = 1'b1;
      case (ph)
        2'd0:    word_nxt = {c0.b, c0.g};
        2'd1:    word_nxt = {c0.r, c1.b};
        default: word_nxt = {c1.g, c1.r};
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_cnt        <= '0;
      ph              <= 2'd0;
      sec_cnt         <= '0;
      bus.wr_data     <= '0;
      bus.wr_start_en <= 1'b0;
      bus.wr_sec_addr <= '0;
    end else begin
      bus.wr_start_en <= (state == S_START);
      if (state == S_START) bus.wr_sec_addr <= SECTION_ADDR + 32'(sec_cnt);
      if (start_acc) begin
        word_cnt <= '0;
        ph       <= 2'd0;
        sec_cnt  <= '0;
      end else begin
        if (req_ok) begin
          bus.wr_data <= word_nxt;
          if (word_cnt != WC_W'(TOTAL_WORDS)) word_cnt <= word_cnt + 1'b1;
          if (is_pix) ph <= (ph == 2'd2) ? 2'd0 : ph + 2'd1;
        end
        if ((state == S_WAIT) && busy_fall) sec_cnt <= sec_cnt + 16'd1;
      end
    end
  end

endmodule

// File: doc/sd_write_photo.md
Name: sd_write_photo

Overview:
Screenshot path: reads one RGB565 frame sequentially from the SDRAM read port and expands each pixel to 24-bit BGR. Emits a complete 24-bpp BMP file (54-byte header + pixels) as 16-bit words to the SD-card sector writer. Writes the file to consecutive sectors starting at SECTION_ADDR and zero-pads the final sector. Sits between the SDRAM controller read FIFO and the SD write controller; it is the write-side counterpart of the photo-load path.

Parameters:
SECTION_ADDR, 32'd69760, first SD sector of the saved file
IMG_W, 640, image width in pixels; must be a multiple of 4 (no BMP row padding)
IMG_H, 480, image height in pixels (header height field is positive)
Derived localparams: PIX_NUM=IMG_W*IMG_H; FILE_BYTES=54+3*PIX_NUM; SEC_NUM=ceil(FILE_BYTES/512); HDR_WORDS=27; PIX_WORDS=3*PIX_NUM/2

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
capture_start  in  1  one-cycle pulse; begin saving one frame
capture_busy  out  1  high from accepted start until done
capture_done  out  1  one-cycle pulse after the last sector's wr_busy falls
sdram_rd_rst  out  1  one-cycle pulse; rewinds SDRAM read pointer to pixel 0
sdram_rd_en  out  1  read strobe; sdram_rd_data valid the following cycle
sdram_rd_data  in  16  RGB565 pixel {R5,G6,B5}
wr_start_en  out  1  one-cycle pulse; starts a 512-byte sector write
wr_sec_addr  out  32  sector address, stable while wr_busy is high
wr_busy  in  1  SD writer busy; falling edge = sector complete
wr_req  in  1  SD writer requests the next word
wr_data  out  16  data word; first file byte on [15:8], second on [7:0]

Behaviour:
- Reset: every output 0, wr_sec_addr=0, all counters 0, FSM in IDLE.
- wr_busy is double-registered; neg edge = d1 & ~d0.
- FSM:
  - IDLE: on capture_start pulse sdram_rd_rst, go PREFETCH. Asserts capture_busy.
  - PREFETCH: issue 2 sdram_rd_en on consecutive cycles; capture pixels into pix0/pix1; go START.
  - START: pulse wr_start_en; wr_sec_addr=SECTION_ADDR+sec_cnt; go WAIT.
  - WAIT: serve wr_req. On neg edge: sec_cnt+1; if sec_cnt==SEC_NUM-1 go DONE, else go START.
  - DONE: pulse capture_done for 1 cycle, clear capture_busy, go IDLE.
- capture_start while busy: ignored.
- Word stream: word_cnt 0..SEC_NUM*256-1 advances once per wr_req. wr_data is registered and updated the cycle after wr_req, so it is valid before the next request.
  - word_cnt<27: header word.
  - word_cnt<27+PIX_WORDS: pixel word.
  - Otherwise: 16'h0000 padding.
  - wr_data holds its value between requests.
- Header bytes, little-endian multi-byte fields:
  - 'B','M'; FILE_BYTES(4); 0(4); 54(4); 40(4); IMG_W(4); IMG_H(4); 1(2); 24(2); 0(4); 3*PIX_NUM(4); 0(16).
- Expansion: R8={R5,R5[4:2]}, G8={G6,G6[5:4]}, B8={B5,B5[4:2]}.
- Pixel pair packing, phase 0..2:
  - Phase 0: {B0,G0}.
  - Phase 1: {R0,B1}.
  - Phase 2: {G1,R1}.
- Refill: after phase-2 word is latched, issue 2 sdram_rd_en to reload pix0/pix1. Suppress refill once PIX_NUM pixels have been read. No rd_en outside PREFETCH/refill.
- Timing requirement on the writer: consecutive wr_req ≥4 clk apart (SPI writer spaces them ≥16). The refill completes within 3 cycles.
- wr_req outside WAIT: ignored, no counter change.
- Counter widths: word_cnt ≥ log2(SEC_NUM*256)+1 bits; sec_cnt 16 bits.
- Reset mid-operation: immediate abort to IDLE. Partial sectors are not completed; SD controller reset is external.

Decomposition:
- Shared package: BMP_HEAD_NUM=54, SD_SEC_WORDS=256, BMP magic bytes, RGB565→888 expansion function. These are shared with the load path.
- One sub-module: bmp_header_rom (combinational: word index 0..26 + IMG_W/IMG_H/FILE_BYTES → 16-bit header word).
- Sector FSM and pixel packer stay in the top module.

Test Plan:
- IMG_W=4, IMG_H=2, capture_start, writer model requesting every 16 clk:
  - Exactly 1 wr_start_en, wr_sec_addr=SECTION_ADDR.
  - Words 0..2 = 16'h424D, 16'h4E00, 16'h0000.
  - Words 39..255 = 0.
  - capture_done 1 cycle after the busy fall is detected.
- Pixels 16'hF800, 16'h07E0:
  - Word27 = 16'h00 00, {B0=00,G0=00} → 16'h0000.
  - Word28 = {R0=FF,B1=00} = 16'hFF00.
  - Word29 = {G1=FF,R1=00} = 16'hFF00.
- Pixel 16'hFFFF pair → words 16'hFFFF ×3; pixel 16'h0821 (R1,G1,B1) → bytes B=08, G=04, R=08.
- IMG_W=16, IMG_H=16 (822 bytes): 2 sectors at SECTION_ADDR and +1, 768 pixel bytes, last 202 bytes 0. Exactly 256 sdram_rd_en total.
- capture_start during busy → no restart, sector count unchanged. wr_req asserted in IDLE → wr_data and counters unchanged.
- rst_n low mid-sector-1 → all outputs 0 asynchronously. A new capture_start afterwards restarts at SECTION_ADDR with sdram_rd_rst and word 16'h424D.
